// File: rtl/mmio_pkg.sv
// Shared constants for the AIC MMIO front end: register byte offsets, FSM states and window sizing.
package mmio_pkg;

    localparam logic [31:0] OFF_BASE    = 32'h00;
    localparam logic [31:0] OFF_ENABLE  = 32'h04;
    localparam logic [31:0] OFF_PENDING = 32'h08;
    localparam logic [31:0] OFF_MODE    = 32'h0C;
    localparam logic [31:0] OFF_HANDLER = 32'h10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SERVICE
    } aic_state_t;

    // Window length in bytes: four control words plus one handler word per line.
    function automatic logic [32:0] win_bytes(input int n_irq);
        return 33'(4 * (4 + n_irq));
    endfunction

endpackage

// File: rtl/aic_prio_enc.sv
// Lowest-index-wins priority encoder for the interrupt request vector.
module aic_prio_enc #(
    parameter int N = 24
) (
    input  logic [N-1:0] i_req,
    output logic [4:0]   o_idx,
    output logic         o_any
);

    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) o_idx = 5'(i);
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/mmio_aic.sv
// MMIO front end: relocatable interrupt-controller register window, everything else forwarded to SRAM.
module mmio_aic
    import mmio_pkg::*;
#(
    parameter int          N_IRQ      = 24,
    parameter int          NMI_COUNT  = 2,
    parameter logic [31:0] RESET_BASE = 32'hFFFF_FF00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    output logic             ready,
    input  logic [31:0]      addr,
    input  logic             rw,
    input  logic [31:0]      dtw,
    output logic [31:0]      dtr,
    output logic             sval,
    input  logic             srdy,
    output logic             srw,
    output logic [31:0]      saddr,
    output logic [31:0]      sdtw,
    input  logic [31:0]      sdtr,
    input  logic [N_IRQ-1:0] interrupts,
    input  logic             iack,
    input  logic             eoi,
    output logic             intrq,
    output logic             nmi,
    output logic [4:0]       vec,
    output logic [31:0]      handler,
    output logic             busy
);

    logic [31:0]      r_base;
    logic [N_IRQ-1:0] r_enable;
    logic [N_IRQ-1:0] r_mode;
    logic [N_IRQ-1:0] r_pend;
    logic [N_IRQ-1:0] r_prev;
    logic [31:0]      r_handler [N_IRQ];
    aic_state_t       r_state;
    logic             r_wrdy;
    logic             r_intrq;
    logic             r_nmi;
    logic             r_busy;
    logic [4:0]       r_vec;

    logic [32:0]      w_lo, w_hi, w_a;
    logic             w_hit, w_wr;
    logic [31:0]      w_off, w_word, w_rd;
    logic             w_sel_base, w_sel_en, w_sel_pend, w_sel_mode;
    logic [N_IRQ-1:0] w_sel_h;
    logic [N_IRQ-1:0] w_nmi_mask, w_pend_live, w_req, w_set, w_clr, w_mode_nx;
    logic [4:0]       w_pidx;
    logic             w_pany, w_req_vec;

    // 33-bit compare so a window near the top of the address space never wraps.
    assign w_a   = {1'b0, addr};
    assign w_lo  = {1'b0, r_base};
    assign w_hi  = w_lo + win_bytes(N_IRQ);
    assign w_hit = (w_a >= w_lo) && (w_a < w_hi);
    assign w_off  = addr - r_base;
    assign w_word = w_off >> 2;
    assign w_wr   = valid & w_hit & rw & ~r_wrdy;

    assign w_sel_base = (w_word == (OFF_BASE >> 2));
    assign w_sel_en   = (w_word == (OFF_ENABLE >> 2));
    assign w_sel_pend = (w_word == (OFF_PENDING >> 2));
    assign w_sel_mode = (w_word == (OFF_MODE >> 2));

    always_comb begin
        w_sel_h    = '0;
        w_nmi_mask = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            w_sel_h[i]    = (w_word == (OFF_HANDLER >> 2) + 32'(i));
            w_nmi_mask[i] = (i < NMI_COUNT);
        end
    end

    // Edge lines report the latched bit, level lines report the live input.
    assign w_pend_live = (r_pend & r_mode) | (interrupts & ~r_mode);
    assign w_req       = w_pend_live & (r_enable | w_nmi_mask);
    assign w_set       = r_mode & interrupts & ~r_prev;
    assign w_mode_nx   = (w_wr && w_sel_mode) ? dtw[N_IRQ-1:0] : r_mode;

    aic_prio_enc #(.N(N_IRQ)) u_prio (
        .i_req (w_req),
        .o_idx (w_pidx),
        .o_any (w_pany)
    );

    always_comb begin
        w_req_vec = 1'b0;
        w_clr     = (w_wr && w_sel_pend) ? dtw[N_IRQ-1:0] : '0;
        handler   = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (r_vec == 5'(i)) begin
                w_req_vec = w_req[i];
                handler   = r_handler[i];
                if (r_state == ST_REQ && iack) w_clr[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_rd = '0;
        if (w_sel_base)      w_rd = r_base;
        else if (w_sel_en)   w_rd[N_IRQ-1:0] = r_enable;
        else if (w_sel_pend) w_rd[N_IRQ-1:0] = w_pend_live;
        else if (w_sel_mode) w_rd[N_IRQ-1:0] = r_mode;
        for (int i = 0; i < N_IRQ; i++) begin
            if (w_sel_h[i]) w_rd = r_handler[i];
        end
    end

    // The write-acknowledge cycle belongs to the AIC even if a BASE write just moved the window.
    assign ready = r_wrdy | (w_hit ? (valid & ~rw) : srdy);
    assign sval  = valid & ~w_hit & ~r_wrdy;
    assign dtr   = w_hit ? w_rd : sdtr;
    assign srw   = rw;
    assign saddr = addr;
    assign sdtw  = dtw;

    assign intrq = r_intrq;
    assign nmi   = r_nmi;
    assign vec   = r_vec;
    assign busy  = r_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_base   <= RESET_BASE & 32'hFFFF_FFFC;
            r_enable <= '0;
            r_mode   <= '0;
            r_pend   <= '0;
            r_prev   <= '0;
            for (int i = 0; i < N_IRQ; i++) r_handler[i] <= '0;
            r_state  <= ST_IDLE;
            r_wrdy   <= 1'b0;
            r_intrq  <= 1'b0;
            r_nmi    <= 1'b0;
            r_busy   <= 1'b0;
            r_vec    <= '0;
        end else begin
            r_wrdy <= w_wr;
            r_prev <= interrupts;
            r_mode <= w_mode_nx;
            // Set beats clear; level lines never keep a latched bit.
            r_pend <= ((r_pend & ~w_clr) | w_set) & w_mode_nx;
            if (w_wr && w_sel_base) r_base   <= {dtw[31:2], 2'b00};
            if (w_wr && w_sel_en)   r_enable <= dtw[N_IRQ-1:0];
            for (int i = 0; i < N_IRQ; i++) begin
                if (w_wr && w_sel_h[i]) r_handler[i] <= dtw;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_pany) begin
                        r_state <= ST_REQ;
                        r_intrq <= 1'b1;
                        r_vec   <= w_pidx;
                        r_nmi   <= (w_pidx < 5'(NMI_COUNT));
                    end
                end
                ST_REQ: begin
                    if (iack) begin
                        r_state <= ST_SERVICE;
                        r_intrq <= 1'b0;
                        r_busy  <= 1'b1;
                    end else if (!w_req_vec) begin
                        r_state <= ST_IDLE;
                        r_intrq <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (eoi) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_aic.sv
// Bench for mmio_aic: directed scenarios with literal expectations plus randomized traffic against a cycle model.
module tb_mmio_aic;

    localparam int          N    = 24;
    localparam logic [31:0] RB   = 32'hFFFF_FF00;
    localparam logic [N-1:0] NMIM = 24'h000003;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         valid = 1'b0, rw = 1'b0, srdy = 1'b0, iack = 1'b0, eoi = 1'b0;
    logic [31:0]  addr = '0, dtw = '0, sdtr = '0;
    logic [N-1:0] interrupts = '0;
    logic         ready, sval, srw, intrq, nmi, busy;
    logic [31:0]  dtr, saddr, sdtw, handler;
    logic [4:0]   vec;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    mmio_aic #(.N_IRQ(N), .NMI_COUNT(2), .RESET_BASE(RB)) dut (
        .clk(clk), .reset(reset), .valid(valid), .ready(ready), .addr(addr), .rw(rw),
        .dtw(dtw), .dtr(dtr), .sval(sval), .srdy(srdy), .srw(srw), .saddr(saddr),
        .sdtw(sdtw), .sdtr(sdtr), .interrupts(interrupts), .iack(iack), .eoi(eoi),
        .intrq(intrq), .nmi(nmi), .vec(vec), .handler(handler), .busy(busy)
    );

    // ---------------- behavioural model ----------------
    logic [31:0]  m_base;
    logic [N-1:0] m_en, m_mode, m_latch, m_prev;
    logic [31:0]  m_h [N];
    int           m_st;      // 0 idle, 1 request, 2 service
    logic [4:0]   m_vec;
    logic         m_nmi, m_wrdy;

    task automatic m_reset();
        m_base = RB; m_en = '0; m_mode = '0; m_latch = '0; m_prev = '0;
        for (int i = 0; i < N; i++) m_h[i] = '0;
        m_st = 0; m_vec = '0; m_nmi = 1'b0; m_wrdy = 1'b0;
    endtask

    function automatic logic m_hit(input logic [31:0] a);
        longint lo, aa;
        lo = {32'b0, m_base};
        aa = {32'b0, a};
        return (aa >= lo) && (aa < lo + 4 * (4 + N));
    endfunction

    function automatic logic [N-1:0] m_pending();
        logic [N-1:0] p;
        for (int i = 0; i < N; i++) p[i] = m_mode[i] ? m_latch[i] : interrupts[i];
        return p;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int k;
        k = int'((a - m_base) >> 2);
        case (k)
            0: return m_base;
            1: return {8'b0, m_en};
            2: return {8'b0, m_pending()};
            3: return {8'b0, m_mode};
            default: return (k >= 4 && k < 4 + N) ? m_h[k-4] : 32'h0;
        endcase
    endfunction

    function automatic int m_lowest(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) if (r[i]) return i;
        return 0;
    endfunction

    task automatic m_step();
        logic [N-1:0] req, clr, setm;
        logic wr;
        int k;
        req = m_pending() & (m_en | NMIM);
        wr  = valid && rw && m_hit(addr) && !m_wrdy;
        k   = int'((addr - m_base) >> 2);
        clr = '0;
        case (m_st)
            0: if (req != '0) begin
                   m_st = 1; m_vec = 5'(m_lowest(req)); m_nmi = (m_vec < 5'd2);
               end
            1: if (iack) begin m_st = 2; clr[m_vec] = 1'b1; end
               else if (!req[m_vec]) m_st = 0;
            default: if (eoi) m_st = 0;
        endcase
        setm = m_mode & interrupts & ~m_prev;
        if (wr && k == 2) clr = clr | dtw[N-1:0];
        m_latch = (m_latch & ~clr) | setm;
        if (wr) begin
            if (k == 0) m_base = {dtw[31:2], 2'b00};
            else if (k == 1) m_en = dtw[N-1:0];
            else if (k == 3) m_mode = dtw[N-1:0];
            else if (k >= 4) m_h[k-4] = dtw;
        end
        m_latch = m_latch & m_mode;
        m_prev  = interrupts;
        m_wrdy  = wr;
    endtask

    always @(posedge clk) begin
        if (!reset) m_reset();
        else m_step();
    end

    always @(negedge reset) m_reset();

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        logic h;
        if (chk_on) begin
            h = m_hit(addr);
            chk("ready", 32'(ready), 32'(m_wrdy | (h ? (valid & ~rw) : srdy)));
            chk("sval", 32'(sval), 32'(valid & ~h & ~m_wrdy));
            chk("dtr", dtr, h ? m_read(addr) : sdtr);
            chk("srw", 32'(srw), 32'(rw));
            chk("saddr", saddr, addr);
            chk("sdtw", sdtw, dtw);
            chk("intrq", 32'(intrq), 32'(m_st == 1));
            chk("busy", 32'(busy), 32'(m_st == 2));
            chk("vec", 32'(vec), 32'(m_vec));
            chk("nmi", 32'(nmi), 32'(m_nmi));
            chk("handler", handler, m_h[m_vec]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_idle();
        valid = 1'b0; rw = 1'b0; addr = '0; dtw = '0;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        valid = 1'b1; rw = 1'b1; addr = a; dtw = d;
        tick();
        tick();
        bus_idle();
    endtask

    task automatic bus_rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp,
                              input logic exp_sval);
        valid = 1'b1; rw = 1'b0; addr = a;
        #1;
        chk(nm, dtr, exp);
        chk({nm, "_ready"}, 32'(ready), 32'd1);
        chk({nm, "_sval"}, 32'(sval), 32'(exp_sval));
        tick();
        bus_idle();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit exceeded, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        chk_on = 1'b1;
        srdy = 1'b1;
        sdtr = 32'h5A5A_A5A5;
        repeat (3) tick();
        chk("rst_intrq", 32'(intrq), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vec", 32'(vec), 32'd0);
        reset = 1'b1;
        tick();

        bus_rd_chk("base_rd", 32'hFFFF_FF00, 32'hFFFF_FF00, 1'b0);
        bus_rd_chk("last_handler", 32'hFFFF_FF6C, 32'h0, 1'b0);
        bus_rd_chk("past_window", 32'hFFFF_FF70, 32'h5A5A_A5A5, 1'b1);

        valid = 1'b1; rw = 1'b1; addr = 32'hFFFF_FF24; dtw = 32'h1234;
        #1 chk("h5_wr_ready0", 32'(ready), 32'd0);
        tick();
        #1 chk("h5_wr_ready1", 32'(ready), 32'd1);
        tick();
        bus_idle();

        bus_wr(32'hFFFF_FF04, 32'h30);
        bus_wr(32'hFFFF_FF0C, 32'h30);
        interrupts = 24'h30;
        tick();
        chk("edge_latency", 32'(intrq), 32'd0);
        interrupts = '0;
        tick();
        chk("pair_intrq", 32'(intrq), 32'd1);
        chk("pair_vec", 32'(vec), 32'd4);
        chk("pair_nmi", 32'(nmi), 32'd0);
        iack = 1'b1;
        tick();
        iack = 1'b0;
        chk("ack_busy", 32'(busy), 32'd1);
        chk("ack_intrq", 32'(intrq), 32'd0);
        bus_rd_chk("pend_after_ack", 32'hFFFF_FF08, 32'h20, 1'b0);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        chk("eoi_busy", 32'(busy), 32'd0);
        tick();
        chk("second_vec", 32'(vec), 32'd5);
        chk("second_intrq", 32'(intrq), 32'd1);
        chk("second_handler", handler, 32'h1234);
        iack = 1'b1; tick(); iack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        chk("quiet", 32'(intrq), 32'd0);

        bus_wr(32'hFFFF_FF04, 32'h0);
        interrupts = 24'h2;
        tick();
        chk("nmi_intrq", 32'(intrq), 32'd1);
        chk("nmi_vec", 32'(vec), 32'd1);
        chk("nmi_flag", 32'(nmi), 32'd1);
        iack = 1'b1; interrupts = '0; tick(); iack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();

        bus_wr(32'hFFFF_FF04, 32'h8);
        interrupts = 24'h8;
        tick();
        chk("lvl_intrq", 32'(intrq), 32'd1);
        chk("lvl_vec", 32'(vec), 32'd3);
        chk("lvl_nmi", 32'(nmi), 32'd0);
        interrupts = '0;
        tick();
        chk("spurious_drop", 32'(intrq), 32'd0);
        iack = 1'b1; tick(); iack = 1'b0;
        chk("idle_iack_ignored", 32'(busy), 32'd0);

        bus_wr(32'hFFFF_FF04, 32'h30);
        interrupts = 24'h10; tick();
        interrupts = '0; tick();
        valid = 1'b1; rw = 1'b1; addr = 32'hFFFF_FF08; dtw = 32'h10;
        interrupts = 24'h10;
        tick();
        tick();
        bus_idle();
        bus_rd_chk("w1c_set_wins", 32'hFFFF_FF08, 32'h10, 1'b0);
        interrupts = '0;
        bus_wr(32'hFFFF_FF08, 32'h10);
        tick();
        chk("w1c_cleared", 32'(intrq), 32'd0);

        bus_wr(32'hFFFF_FF00, 32'h0000_1003);
        bus_rd_chk("new_base", 32'h0000_1000, 32'h0000_1000, 1'b0);
        bus_rd_chk("moved_handler", 32'h0000_1024, 32'h1234, 1'b0);
        bus_rd_chk("old_base_sram", 32'hFFFF_FF00, 32'h5A5A_A5A5, 1'b1);
        bus_rd_chk("new_past_end", 32'h0000_1070, 32'h5A5A_A5A5, 1'b1);

        interrupts = 24'h10; tick();
        interrupts = '0; tick();
        iack = 1'b1; tick(); iack = 1'b0;
        chk("svc_before_reset", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_intrq", 32'(intrq), 32'd0);
        chk("reset_vec", 32'(vec), 32'd0);
        bus_rd_chk("reset_base", 32'hFFFF_FF00, 32'hFFFF_FF00, 1'b0);
        reset = 1'b1;
        tick();

        for (int c = 0; c < 3000; c++) begin
            int op;
            op    = int'($urandom_range(0, 9));
            valid = ($urandom_range(0, 9) < 6);
            rw    = 1'b0;
            dtw   = $urandom;
            case (op)
                0, 1, 2: addr = RB + 32'(4 * $urandom_range(0, 27));
                3: begin rw = 1'b1; addr = RB + 32'h04; end
                4: begin rw = 1'b1; addr = RB + 32'h0C; end
                5: begin rw = 1'b1; addr = RB + 32'h08; end
                6: begin rw = 1'b1; addr = RB + 32'(4 * $urandom_range(4, 27)); end
                7: begin rw = 1'($urandom_range(0, 1)); addr = $urandom & 32'h7FFF_FFFC; end
                8: begin
                    rw = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 1) == 1) addr = RB + 32'(4 * (28 + $urandom_range(0, 8)));
                    else addr = RB - 32'(4 * $urandom_range(1, 4));
                end
                default: addr = $urandom;
            endcase
            srdy = 1'($urandom_range(0, 1));
            sdtr = $urandom;
            interrupts = interrupts ^ N'($urandom & $urandom & $urandom);
            iack = ($urandom_range(0, 3) == 0);
            eoi  = ($urandom_range(0, 3) == 0);
            tick();
        end

        bus_idle();
        iack = 1'b0; eoi = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
